// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   funct3 size/extension codes, FSM state encoding, exception cause codes,
//   and a helper that classifies a funct3 code as legal or illegal.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_MIS_LD  = 2'b01;
  localparam logic [1:0] EXC_MIS_ST  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_RD  = 3'd1,
    WAIT_RD = 3'd2,
    REQ_WR  = 3'd3,
    WAIT_WR = 3'd4,
    DONE    = 3'd5
  } lsu_state_t;

  // Only the five size/extension codes are meaningful; everything else traps.
  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align -- combinational byte-lane steering for the LSU.
//   word      : 32-bit memory word (lane k = bits [8k+7:8k])
//   addr_lo   : byte offset within the word
//   funct3    : access size / extension code
//   wdata     : right-aligned store data (only the low halfword is ever merged)
//   load_data : selected lane(s), sign- or zero-extended to 32 bits
//   merged    : word with the addressed lane(s) replaced by wdata (RMW image)
// Halfword lanes use addr_lo[1] only, so a halfword at an odd offset is
// treated as aligned to its containing halfword.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction, extension and merge.
  always_comb begin
    byte_s    = word[{addr_lo, 3'b000} +: 8];
    half_s    = word[{addr_lo[1], 4'b0000} +: 16];
    load_data = word;
    merged    = word;
    case (funct3)
      F3_B: begin
        load_data = {{24{byte_s[7]}}, byte_s};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      F3_BU: begin
        load_data = {24'h000000, byte_s};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        load_data = {{16{half_s[15]}}, half_s};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata;
      end
      F3_HU: begin
        load_data = {16'h0000, half_s};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata;
      end
      default: begin
        load_data = word;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator -- load/store unit driving a word-granular data memory.
//   Execute side : op_valid/op_ready handshake, op_store, op_funct3, op_addr,
//                  op_wdata, op_tag.
//   Writeback    : res_valid pulse with res_wb, res_data, res_tag.
//   Memory side  : mem_req/mem_we/mem_a/mem_wd out, mem_rd/mem_ready in
//                  (ready is a one-cycle pulse one cycle after mem_req).
//   Exceptions   : exc_valid pulse with exc_cause, coincident with res_valid.
// Byte/halfword stores are done as read-modify-write of the containing word.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses;
// without it the offending low address bits are ignored.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_store,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  input  logic [TAG_W-1:0]  op_tag,
  output logic              res_valid,
  output logic              res_wb,
  output logic [31:0]       res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  input  logic              mem_ready,
  output logic              exc_valid,
  output logic [1:0]        exc_cause
);

  lsu_state_t state_r, next_state_s;

  logic              accept_s, legal_s, misalign_s, rd_resp_s;
  logic [1:0]        trap_cause_s;
  logic [31:0]       load_data_s, merged_s;

  logic [1:0]        addr_lo_r;
  logic [2:0]        f3_r;
  logic [15:0]       wdata_r;
  logic [TAG_W-1:0]  tag_r;
  logic              store_r;

  logic              op_ready_nxt_s, mem_req_nxt_s, mem_we_nxt_s;
  logic              res_valid_nxt_s, res_wb_nxt_s, exc_valid_nxt_s;
  logic [31:0]       res_data_nxt_s, mem_a_nxt_s, mem_wd_nxt_s;
  logic [TAG_W-1:0]  res_tag_nxt_s;
  logic [1:0]        exc_cause_nxt_s;

  assign accept_s  = (state_r == IDLE) && op_valid;
  assign legal_s   = f3_legal(op_funct3);
  assign rd_resp_s = (state_r == WAIT_RD) && mem_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = (((op_funct3 == F3_H) || (op_funct3 == F3_HU)) && op_addr[0]) ||
                      ((op_funct3 == F3_W) && (op_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  // Illegal funct3 takes priority over misalignment.
  assign trap_cause_s = !legal_s ? EXC_ILLEGAL : (op_store ? EXC_MIS_ST : EXC_MIS_LD);

  // Read data is steered straight from mem_rd, which is only valid in the ready cycle.
  lsu_lane_align u_lane_align (
    .word      (mem_rd),
    .addr_lo   (addr_lo_r),
    .funct3    (f3_r),
    .wdata     (wdata_r),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; responses outside WAIT_* states are ignored.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!op_valid) begin
          next_state_s = IDLE;
        end else if (!legal_s || misalign_s) begin
          next_state_s = DONE;
        end else if (op_store && (op_funct3 == F3_W)) begin
          next_state_s = REQ_WR;
        end else begin
          next_state_s = REQ_RD;
        end
      end
      REQ_RD:  next_state_s = WAIT_RD;
      WAIT_RD: begin
        if (!mem_ready) begin
          next_state_s = WAIT_RD;
        end else if (store_r) begin
          next_state_s = REQ_WR;
        end else begin
          next_state_s = DONE;
        end
      end
      REQ_WR:  next_state_s = WAIT_WR;
      WAIT_WR: begin
        if (mem_ready) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT_WR;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: next-cycle values of every registered output.
  always_comb begin
    op_ready_nxt_s  = (next_state_s == IDLE);
    mem_req_nxt_s   = (next_state_s == REQ_RD) || (next_state_s == REQ_WR);
    mem_we_nxt_s    = (next_state_s == REQ_WR);
    res_valid_nxt_s = (next_state_s == DONE);
    res_wb_nxt_s    = 1'b0;
    res_data_nxt_s  = 32'h0000_0000;
    res_tag_nxt_s   = {TAG_W{1'b0}};
    exc_valid_nxt_s = 1'b0;
    exc_cause_nxt_s = EXC_NONE;
    mem_a_nxt_s     = mem_a;
    mem_wd_nxt_s    = mem_wd;

    // A word store issues op_wdata directly; an RMW later overwrites mem_wd.
    if (accept_s) begin
      mem_a_nxt_s  = 32'({op_addr[ADDR_W-1:2], 2'b00});
      mem_wd_nxt_s = op_wdata;
    end else if (rd_resp_s && store_r) begin
      mem_a_nxt_s  = mem_a;
      mem_wd_nxt_s = merged_s;
    end else begin
      mem_a_nxt_s  = mem_a;
      mem_wd_nxt_s = mem_wd;
    end

    // IDLE -> DONE only happens for a trapped op.
    if ((next_state_s == DONE) && (state_r == IDLE)) begin
      res_tag_nxt_s   = op_tag;
      exc_valid_nxt_s = 1'b1;
      exc_cause_nxt_s = trap_cause_s;
    end else if (next_state_s == DONE) begin
      res_wb_nxt_s    = !store_r;
      res_data_nxt_s  = store_r ? 32'h0000_0000 : load_data_s;
      res_tag_nxt_s   = tag_r;
    end else begin
      res_wb_nxt_s    = 1'b0;
      res_data_nxt_s  = 32'h0000_0000;
      res_tag_nxt_s   = {TAG_W{1'b0}};
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= 32'h0000_0000;
      mem_wd    <= 32'h0000_0000;
      res_valid <= 1'b0;
      res_wb    <= 1'b0;
      res_data  <= 32'h0000_0000;
      res_tag   <= {TAG_W{1'b0}};
      exc_valid <= 1'b0;
      exc_cause <= EXC_NONE;
    end else begin
      op_ready  <= op_ready_nxt_s;
      mem_req   <= mem_req_nxt_s;
      mem_we    <= mem_we_nxt_s;
      mem_a     <= mem_a_nxt_s;
      mem_wd    <= mem_wd_nxt_s;
      res_valid <= res_valid_nxt_s;
      res_wb    <= res_wb_nxt_s;
      res_data  <= res_data_nxt_s;
      res_tag   <= res_tag_nxt_s;
      exc_valid <= exc_valid_nxt_s;
      exc_cause <= exc_cause_nxt_s;
    end
  end

  // Op attributes latched at accept for use in later states.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_lo_r <= 2'b00;
      f3_r      <= 3'b000;
      wdata_r   <= 16'h0000;
      tag_r     <= {TAG_W{1'b0}};
      store_r   <= 1'b0;
    end else if (accept_s) begin
      addr_lo_r <= op_addr[1:0];
      f3_r      <= op_funct3;
      wdata_r   <= op_wdata[15:0];
      tag_r     <= op_tag;
      store_r   <= op_store;
    end else begin
      addr_lo_r <= addr_lo_r;
      f3_r      <= f3_r;
      wdata_r   <= wdata_r;
      tag_r     <= tag_r;
      store_r   <= store_r;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator -- directed self-checking bench for lsu_mem_initiator.
// A small memory responder returns mem_ready one cycle after each mem_req,
// presenting rd_word in that cycle and all-ones otherwise.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_valid, op_ready, op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic [4:0]  op_tag;
  logic        res_valid, res_wb;
  logic [31:0] res_data;
  logic [4:0]  res_tag;
  logic        mem_req, mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_ready;
  logic        exc_valid;
  logic [1:0]  exc_cause;

  int errors = 0;
  int checks = 0;

  logic        resp_en, req_prev;
  logic [31:0] rd_word;

  int          rd_cyc, wr_cyc, res_cyc, exc_cyc, rdy_cyc, nreq, nres, coinc, busy_rdy;
  logic [31:0] rd_a, wr_a, wr_wd, r_data;
  logic        r_wb, acc_rdy;
  logic [4:0]  r_tag;
  logic [1:0]  r_cause;

  lsu_mem_initiator #(.TAG_W(5), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .op_valid(op_valid), .op_ready(op_ready), .op_store(op_store),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata), .op_tag(op_tag),
    .res_valid(res_valid), .res_wb(res_wb), .res_data(res_data), .res_tag(res_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .mem_ready(mem_ready),
    .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (resp_en) begin
      mem_ready = req_prev;
      mem_rd    = req_prev ? rd_word : 32'hFFFF_FFFF;
    end
    req_prev = mem_req;
  endtask

  // Present one op for a single cycle, then record 20 cycles of activity.
  // Cycle numbers count from the accept cycle (= 0).
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] tag, input logic [31:0] rw);
    rd_word = rw; resp_en = 1'b1; req_prev = 1'b0;
    rd_cyc = -1; wr_cyc = -1; res_cyc = -1; exc_cyc = -1; rdy_cyc = -1;
    nreq = 0; nres = 0; coinc = 0; busy_rdy = 0;
    rd_a = 32'h0; wr_a = 32'h0; wr_wd = 32'h0; r_data = 32'h0; r_wb = 1'b0;
    r_tag = 5'h0; r_cause = 2'b00;
    op_valid = 1'b1; op_store = st; op_funct3 = f3; op_addr = addr; op_wdata = wd; op_tag = tag;
    acc_rdy = op_ready;
    tick();
    op_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_req) nreq++;
      if (mem_req && mem_ready) coinc++;
      if (mem_req && !mem_we && rd_cyc < 0) begin rd_cyc = k; rd_a = mem_a; end
      if (mem_req && mem_we && wr_cyc < 0) begin wr_cyc = k; wr_a = mem_a; wr_wd = mem_wd; end
      if (res_valid) begin
        nres++;
        if (res_cyc < 0) begin res_cyc = k; r_data = res_data; r_wb = res_wb; r_tag = res_tag; end
      end
      if (exc_valid && exc_cyc < 0) begin exc_cyc = k; r_cause = exc_cause; end
      if (res_cyc >= 0 && op_ready && rdy_cyc < 0) rdy_cyc = k;
      if (res_cyc < 0 && op_ready) busy_rdy++;
      tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; op_valid = 1'b0; op_store = 1'b0; op_funct3 = 3'b000;
    op_addr = 32'h0; op_wdata = 32'h0; op_tag = 5'h0;
    mem_ready = 1'b0; mem_rd = 32'hFFFF_FFFF; resp_en = 1'b0; req_prev = 1'b0; rd_word = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
    checks++; if ({mem_req, mem_we, res_valid, res_wb, exc_valid} !== 5'b00000) begin errors++;
      $display("FAIL reset_strobes: got %b expected 00000", {mem_req, mem_we, res_valid, res_wb, exc_valid}); end
    checks++; if ({res_data, mem_a, mem_wd} !== 96'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", {res_data, mem_a, mem_wd}); end
    checks++; if ({res_tag, exc_cause} !== 7'h0) begin errors++;
      $display("FAIL reset_tag_cause: got %h expected 0", {res_tag, exc_cause}); end
    rstn = 1'b1;
    tick();
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", op_ready); end
  endtask

  task automatic test_lw();
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 5'h0A, 32'hDEADBEEF);
    checks++; if (acc_rdy !== 1'b1) begin errors++; $display("FAIL lw_accept_ready: got %b expected 1", acc_rdy); end
    checks++; if (rd_cyc !== 1) begin errors++; $display("FAIL lw_req_cycle: got %0d expected 1", rd_cyc); end
    checks++; if (rd_a !== 32'h10) begin errors++; $display("FAIL lw_mem_a: got %h expected 00000010", rd_a); end
    checks++; if (wr_cyc !== -1) begin errors++; $display("FAIL lw_no_write: got %0d expected -1", wr_cyc); end
    checks++; if (res_cyc !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", res_cyc); end
    checks++; if (r_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", r_data); end
    checks++; if (r_wb !== 1'b1) begin errors++; $display("FAIL lw_wb: got %b expected 1", r_wb); end
    checks++; if (r_tag !== 5'h0A) begin errors++; $display("FAIL lw_tag: got %h expected 0a", r_tag); end
    checks++; if (exc_cyc !== -1) begin errors++; $display("FAIL lw_no_exc: got %0d expected -1", exc_cyc); end
    checks++; if (rdy_cyc !== 4) begin errors++; $display("FAIL lw_next_accept: got %0d expected 4", rdy_cyc); end
    checks++; if (busy_rdy !== 0) begin errors++; $display("FAIL lw_busy_ready: got %0d expected 0", busy_rdy); end
    checks++; if (nres !== 1) begin errors++; $display("FAIL lw_one_result: got %0d expected 1", nres); end
  endtask

  task automatic test_load_ext();
    run_op(1'b0, 3'b000, 32'h13, 32'h0, 5'h01, 32'h80FF1234);
    checks++; if (r_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", r_data); end
    checks++; if (res_cyc !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", res_cyc); end
    run_op(1'b0, 3'b100, 32'h13, 32'h0, 5'h02, 32'h80FF1234);
    checks++; if (r_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", r_data); end
    checks++; if (rd_a !== 32'h10) begin errors++; $display("FAIL lbu_mem_a: got %h expected 00000010", rd_a); end
    run_op(1'b0, 3'b001, 32'h12, 32'h0, 5'h03, 32'h80FF1234);
    checks++; if (r_data !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_data: got %h expected ffff80ff", r_data); end
    run_op(1'b0, 3'b101, 32'h10, 32'h0, 5'h04, 32'h80FF1234);
    checks++; if (r_data !== 32'h00001234) begin errors++; $display("FAIL lhu_data: got %h expected 00001234", r_data); end
  endtask

  task automatic test_sb();
    run_op(1'b1, 3'b000, 32'h22, 32'hFFFFFFAB, 5'h07, 32'h11223344);
    checks++; if (rd_cyc !== 1) begin errors++; $display("FAIL sb_rd_cycle: got %0d expected 1", rd_cyc); end
    checks++; if (wr_cyc !== 3) begin errors++; $display("FAIL sb_wr_cycle: got %0d expected 3", wr_cyc); end
    checks++; if (wr_a !== 32'h20) begin errors++; $display("FAIL sb_wr_a: got %h expected 00000020", wr_a); end
    checks++; if (wr_wd !== 32'h11AB3344) begin errors++; $display("FAIL sb_wd: got %h expected 11ab3344", wr_wd); end
    checks++; if (res_cyc !== 5) begin errors++; $display("FAIL sb_latency: got %0d expected 5", res_cyc); end
    checks++; if ({r_wb, r_data} !== 33'h0) begin errors++; $display("FAIL sb_result: got %b/%h expected 0/0", r_wb, r_data); end
    checks++; if (coinc !== 0) begin errors++; $display("FAIL sb_req_ready_overlap: got %0d expected 0", coinc); end
    checks++; if (nreq !== 2) begin errors++; $display("FAIL sb_req_count: got %0d expected 2", nreq); end
  endtask

  task automatic test_sw();
    run_op(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 5'h08, 32'h0);
    checks++; if (rd_cyc !== -1) begin errors++; $display("FAIL sw_no_read: got %0d expected -1", rd_cyc); end
    checks++; if (wr_cyc !== 1) begin errors++; $display("FAIL sw_wr_cycle: got %0d expected 1", wr_cyc); end
    checks++; if (wr_wd !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_wd: got %h expected cafef00d", wr_wd); end
    checks++; if (res_cyc !== 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", res_cyc); end
  endtask

  task automatic test_sh();
    run_op(1'b1, 3'b001, 32'h6, 32'h0000BEEF, 5'h09, 32'h01020304);
    checks++; if (wr_a !== 32'h4) begin errors++; $display("FAIL sh_mem_a: got %h expected 00000004", wr_a); end
    checks++; if (wr_wd !== 32'hBEEF0304) begin errors++; $display("FAIL sh_wd: got %h expected beef0304", wr_wd); end
    run_op(1'b1, 3'b001, 32'h5, 32'h0000BEEF, 5'h0B, 32'h01020304);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (nreq !== 0) begin errors++; $display("FAIL sh_mis_no_req: got %0d expected 0", nreq); end
    checks++; if (exc_cyc !== 1) begin errors++; $display("FAIL sh_mis_exc: got %0d expected 1", exc_cyc); end
    checks++; if (r_cause !== 2'b10) begin errors++; $display("FAIL sh_mis_cause: got %b expected 10", r_cause); end
`else
    checks++; if (wr_a !== 32'h4) begin errors++; $display("FAIL sh_odd_mem_a: got %h expected 00000004", wr_a); end
    checks++; if (wr_wd !== 32'h0102BEEF) begin errors++; $display("FAIL sh_odd_wd: got %h expected 0102beef", wr_wd); end
    checks++; if (exc_cyc !== -1) begin errors++; $display("FAIL sh_odd_no_exc: got %0d expected -1", exc_cyc); end
`endif
    checks++; if (nres !== 1) begin errors++; $display("FAIL sh_odd_result: got %0d expected 1", nres); end
  endtask

  task automatic test_illegal();
    run_op(1'b0, 3'b011, 32'h40, 32'h0, 5'h0C, 32'h12345678);
    checks++; if (nreq !== 0) begin errors++; $display("FAIL ill_no_req: got %0d expected 0", nreq); end
    checks++; if (res_cyc !== 1) begin errors++; $display("FAIL ill_res_cycle: got %0d expected 1", res_cyc); end
    checks++; if (exc_cyc !== 1) begin errors++; $display("FAIL ill_exc_cycle: got %0d expected 1", exc_cyc); end
    checks++; if (r_cause !== 2'b11) begin errors++; $display("FAIL ill_cause: got %b expected 11", r_cause); end
    checks++; if (r_tag !== 5'h0C) begin errors++; $display("FAIL ill_tag: got %h expected 0c", r_tag); end
  endtask

  task automatic test_reset_mid();
    int bad;
    resp_en = 1'b0; mem_ready = 1'b0; mem_rd = 32'hFFFF_FFFF; bad = 0;
    op_valid = 1'b1; op_store = 1'b1; op_funct3 = 3'b000; op_addr = 32'h22; op_wdata = 32'hAB; op_tag = 5'h0D;
    tick();
    op_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_rd_req: got %b expected 1", mem_req); end
    tick();
    rstn = 1'b0;
    #1;
    checks++; if ({op_ready, mem_req, res_valid} !== 3'b100) begin errors++;
      $display("FAIL rst_mid_async: got %b expected 100", {op_ready, mem_req, res_valid}); end
    tick(); tick();
    rstn = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rd = 32'h11223344;
    for (int k = 0; k < 8; k++) begin
      if (mem_req || res_valid || exc_valid || !op_ready) bad++;
      tick();
      mem_ready = 1'b0; mem_rd = 32'hFFFF_FFFF;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_stale_ready: got %0d bad cycles expected 0", bad); end
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 5'h0E, 32'h0BADF00D);
    checks++; if (res_cyc !== 3) begin errors++; $display("FAIL rst_mid_lw_latency: got %0d expected 3", res_cyc); end
    checks++; if (r_data !== 32'h0BADF00D) begin errors++; $display("FAIL rst_mid_lw_data: got %h expected 0badf00d", r_data); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_sb();
    test_sw();
    test_sh();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit on the core side of the data-memory word interface (req/we/a/wd in, rd/ready out).
- Accepts one load or store per transaction from the execute stage and issues word-granular memory requests.
- Byte and halfword stores are performed as read-modify-write.
- Returns sign- or zero-extended load data with a destination tag to writeback.

Parameters:
- TAG_W, 5, width of destination register tag carried with each op.
- ADDR_W, 32, width of the byte address; memory word index is addr[ADDR_W-1:2].

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- op_valid  in  1  execute stage presents an op.
- op_ready  out  1  LSU can accept an op this cycle.
- op_store  in  1  1 = store, 0 = load.
- op_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes illegal.
- op_addr  in  ADDR_W  byte address.
- op_wdata  in  32  store data, right-aligned.
- op_tag  in  TAG_W  destination tag for loads.
- res_valid  out  1  one-cycle completion pulse.
- res_wb  out  1  completion is a load (write back res_data).
- res_data  out  32  extended load data; 0 for stores.
- res_tag  out  TAG_W  tag of the completed op.
- mem_req  out  1  one-cycle request to data memory.
- mem_we  out  1  write qualifier for mem_req.
- mem_a  out  32  byte address; bits [1:0] are always driven 0.
- mem_wd  out  32  write word; lane k = bits [8k+7:8k] = byte at offset k.
- mem_rd  in  32  read word, same lane order; valid only while mem_ready = 1.
- mem_ready  in  1  one-cycle response pulse, one cycle after mem_req.
- exc_valid  out  1  one-cycle exception pulse (see Optional Feature).
- exc_cause  out  2  01 misaligned load, 10 misaligned store, 11 illegal funct3.

Behaviour:
- States: IDLE, REQ_RD, WAIT_RD, REQ_WR, WAIT_WR, DONE.
- All outputs are registered or Moore-decoded from state.
- Reset values (async): state IDLE; op_ready 1; mem_req, mem_we, res_valid, res_wb, exc_valid 0; res_data, res_tag, mem_a, mem_wd, exc_cause 0.
- IDLE: op_ready = 1. On op_valid, latch addr, funct3, wdata and tag. Next state:
  - load -> REQ_RD
  - SW -> REQ_WR
  - SB/SH -> REQ_RD (RMW)
  - illegal funct3 -> DONE, with exc_valid and exc_cause 11 pulsed together with res_valid.
- REQ_RD: mem_req = 1, mem_we = 0 for exactly one cycle -> WAIT_RD.
- WAIT_RD: hold until mem_ready, then capture mem_rd.
  - Load -> DONE, with res_data = extracted lane. B/H sign-extend; BU/HU zero-extend. Lane = addr[1:0] for byte, addr[1] for half.
  - SB/SH -> REQ_WR, with mem_wd = captured word with the selected lane(s) replaced by op_wdata[7:0] or [15:0].
- REQ_WR: mem_req = 1, mem_we = 1, mem_wd stable -> WAIT_WR.
- WAIT_WR: on mem_ready -> DONE.
- DONE: res_valid = 1 for one cycle; res_wb = !store; res_tag = latched tag -> IDLE.
- Latency from accept edge to res_valid:
  - LW/LB/LH: 3 cycles.
  - SW: 3 cycles.
  - SB/SH: 5 cycles.
  - Next accept is possible 1 cycle after res_valid.
- mem_req is never asserted in a cycle where mem_ready = 1; the responder drops ready if both coincide. The REQ_WR issued after WAIT_RD is therefore one cycle later, never the same cycle.
- mem_ready seen in IDLE, REQ_* or DONE is ignored. This covers a stale response after reset mid-transaction.
- mem_rd is sampled only in the mem_ready cycle; the responder drives all-ones afterwards.
- No response timeout: WAIT_* holds indefinitely.
- Reset asserted mid-operation: immediate return to IDLE; no res_valid for the aborted op; a partial RMW write is never issued.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned H/HU (addr[0] = 1) or W (addr[1:0] != 0) skips memory, goes IDLE -> DONE.
  - In DONE: exc_valid = 1, cause 01 (load) or 10 (store), res_wb = 0.
- Undefined:
  - Offending low address bits are treated as 0 (H aligned to the halfword, W to the word); no exception.
  - exc_valid fires only for illegal funct3.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t.
  - exc_cause localparams EXC_MIS_LD, EXC_MIS_ST, EXC_ILLEGAL.
- Sub-module lsu_lane_align: combinational; (word, addr[1:0], funct3, wdata) -> extended load data and merged RMW word. Instantiated once.

Test Plan:
- LW addr 0x10, mem_rd 0xDEADBEEF in ready cycle -> mem_req 1 cycle after accept with mem_a 0x10, we 0; res_valid 3 cycles after accept; res_data 0xDEADBEEF, res_wb 1, res_tag echoed.
- LB addr 0x13 and LBU addr 0x13, word 0x80FF1234 -> res_data 0xFFFFFF80 and 0x00000080 respectively.
- SB addr 0x22, wdata 0xAB, read word 0x11223344 -> read req, then write req exactly 2 cycles later with mem_wd 0x11AB3344, we 1; res_valid 5 cycles after accept, res_wb 0.
- SH addr 0x6 with LSU_MISALIGN_TRAP_EN undefined, wdata 0xBEEF, read word 0x01020304 -> mem_a 0x4, mem_wd 0xBEEF0304. Same op at addr 0x5 with macro defined -> no mem_req, exc_valid with cause 10.
- Reset pulsed during WAIT_RD of an SB; memory ready arrives 1 cycle after reset release -> no write req, no res_valid; op_ready 1; next LW completes normally.
- op_funct3 011 -> no mem_req; res_valid and exc_valid in the same cycle, cause 11.
